// File: rtl/mid_pool_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module : mid_pkg
// Brief  : Widths, default frame geometry and FSM encoding for the pool reader.
// Rev    : 1.0
// ============================================================================
package mid_pkg;

    localparam int DATA_W = 21;
    localparam int ADDR_W = 11;
    localparam int N_CH   = 3;

    localparam logic [ADDR_W-1:0] DEF_IMAGE_WIDTH  = 11'd28;
    localparam logic [ADDR_W-1:0] DEF_IMAGE_HEIGHT = 11'd28;

    typedef logic signed [DATA_W-1:0] pix_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEL   = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mid_pool_reader_if.sv
`default_nettype none
// ============================================================================
// Module : mid_pool_reader_if
// Brief  : Line-buffer read port plus pooled-pixel stream of the pool reader.
// Rev    : 1.0
// ============================================================================
interface mid_pool_reader_if;
    import mid_pkg::*;

    logic              fin_rd;
    logic              bram_toggle;
    pix_t              qa_0, qa_1, qa_2, qa_3;
    pix_t              qb_0, qb_1, qb_2, qb_3;
    pix_t              qc_0, qc_1, qc_2, qc_3;
    logic [ADDR_W-1:0] rd_addr;
    logic              in0_rden, in1_rden, in2_rden, in3_rden;
    pix_t              pa, pb, pc;
    logic              de_out;
    logic              line_done;
    logic              frame_done;
    logic              overrun;

    modport master (
        output fin_rd, bram_toggle,
        output qa_0, qa_1, qa_2, qa_3, qb_0, qb_1, qb_2, qb_3, qc_0, qc_1, qc_2, qc_3,
        input  rd_addr, in0_rden, in1_rden, in2_rden, in3_rden,
        input  pa, pb, pc, de_out, line_done, frame_done, overrun
    );

    modport slave (
        input  fin_rd, bram_toggle,
        input  qa_0, qa_1, qa_2, qa_3, qb_0, qb_1, qb_2, qb_3, qc_0, qc_1, qc_2, qc_3,
        output rd_addr, in0_rden, in1_rden, in2_rden, in3_rden,
        output pa, pb, pc, de_out, line_done, frame_done, overrun
    );

endinterface
`default_nettype wire

// File: rtl/mid_pool_reader_max2_s21.sv
`default_nettype none
// ============================================================================
// Module : max2_s21
// Brief  : Combinational signed max of two 21-bit operands.
// Rev    : 1.0
// ============================================================================
module max2_s21
    import mid_pkg::*;
(
    input  wire pix_t a_i,
    input  wire pix_t b_i,
    output pix_t      max_o
);

    // Ties resolve to a_i, the earlier operand.
    assign max_o = (b_i > a_i) ? b_i : a_i;

endmodule
`default_nettype wire

// File: rtl/mid_pool_reader.sv
`default_nettype none
// ============================================================================
// Module : mid_pool_reader
// Brief  : Reads a finished bank pair and streams 2x2 signed max-pooled pixels.
// Rev    : 1.0
// ============================================================================
module mid_pool_reader
    import mid_pkg::*;
#(
    parameter logic [ADDR_W-1:0] image_width  = DEF_IMAGE_WIDTH,
    parameter logic [ADDR_W-1:0] image_height = DEF_IMAGE_HEIGHT
) (
    input  wire logic        clk,
    input  wire logic        RESET_n,
    mid_pool_reader_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_COL = image_width - 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ROW = (image_height >> 1) - 1'b1;

    generate
        if (image_width[0] != 1'b0) begin : g_bad_width
            $error("mid_pool_reader: image_width must be even");
        end
        if (image_height[0] != 1'b0) begin : g_bad_height
            $error("mid_pool_reader: image_height must be even");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pair_q, pair_d;
    logic              drain_q, drain_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.fin_rd) state_d = S_SEL;
            end
            S_SEL: begin
                pair_d  = bus.bram_toggle;
                addr_d  = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (addr_q == LAST_COL) begin
                    addr_d  = '0;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pair_q  <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
        end
    end

    logic w_rd_en;
    assign w_rd_en      = (state_q == S_READ);
    assign bus.rd_addr  = addr_q;
    assign bus.in0_rden = w_rd_en &  pair_q;
    assign bus.in1_rden = w_rd_en &  pair_q;
    assign bus.in2_rden = w_rd_en & ~pair_q;
    assign bus.in3_rden = w_rd_en & ~pair_q;

    // pair_q stays stable through READ/DRAIN, so it also steers the returning data.
    pix_t top_w  [N_CH];
    pix_t bot_w  [N_CH];
    pix_t vmax_w [N_CH];
    pix_t hmax_w [N_CH];
    pix_t hold_q [N_CH];
    pix_t pool_q [N_CH];

    always_comb begin
        top_w[0] = pair_q ? bus.qa_0 : bus.qa_2;
        bot_w[0] = pair_q ? bus.qa_1 : bus.qa_3;
        top_w[1] = pair_q ? bus.qb_0 : bus.qb_2;
        bot_w[1] = pair_q ? bus.qb_1 : bus.qb_3;
        top_w[2] = pair_q ? bus.qc_0 : bus.qc_2;
        bot_w[2] = pair_q ? bus.qc_1 : bus.qc_3;
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            max2_s21 u_vmax (.a_i(top_w[g]),  .b_i(bot_w[g]),  .max_o(vmax_w[g]));
            max2_s21 u_hmax (.a_i(hold_q[g]), .b_i(vmax_w[g]), .max_o(hmax_w[g]));
        end
    endgenerate

    logic              v1_q, odd1_q, last1_q;
    logic              de_q, line_done_q, frame_done_q, overrun_q;
    logic [ADDR_W-1:0] row_q;

    // v1/odd1/last1 tag the bank data that arrives one cycle after its address.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            v1_q         <= 1'b0;
            odd1_q       <= 1'b0;
            last1_q      <= 1'b0;
            de_q         <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            row_q        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold_q[i] <= '0;
                pool_q[i] <= '0;
            end
        end else begin
            v1_q         <= w_rd_en;
            odd1_q       <= addr_q[0];
            last1_q      <= (addr_q == LAST_COL);
            de_q         <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (v1_q && !odd1_q) begin
                for (int i = 0; i < N_CH; i++) hold_q[i] <= vmax_w[i];
            end
            if (v1_q && odd1_q) begin
                for (int i = 0; i < N_CH; i++) pool_q[i] <= hmax_w[i];
                de_q <= 1'b1;
                if (last1_q) begin
                    line_done_q <= 1'b1;
                    if (row_q == LAST_ROW) begin
                        frame_done_q <= 1'b1;
                        row_q        <= '0;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
            end
            if (bus.fin_rd && (state_q != S_IDLE)) overrun_q <= 1'b1;
        end
    end

    assign bus.pa         = pool_q[0];
    assign bus.pb         = pool_q[1];
    assign bus.pc         = pool_q[2];
    assign bus.de_out     = de_q;
    assign bus.line_done  = line_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mid_pool_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_mid_pool_reader
// Brief  : Directed self-checking bench for mid_pool_reader.
// Rev    : 1.0
// ============================================================================
module tb_mid_pool_reader;

    localparam int W = 28;

    logic clk;
    logic RESET_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    mid_pool_reader_if bus ();

    mid_pool_reader #(.image_width(11'd28), .image_height(11'd28)) dut (
        .clk     (clk),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mem[channel][bank][column]
    logic signed [20:0] mem [3][4][W];

    always @(posedge clk) begin
        if (!RESET_n) begin
            bus.qa_0 <= 21'($urandom); bus.qa_1 <= 21'($urandom);
            bus.qa_2 <= 21'($urandom); bus.qa_3 <= 21'($urandom);
            bus.qb_0 <= 21'($urandom); bus.qb_1 <= 21'($urandom);
            bus.qb_2 <= 21'($urandom); bus.qb_3 <= 21'($urandom);
            bus.qc_0 <= 21'($urandom); bus.qc_1 <= 21'($urandom);
            bus.qc_2 <= 21'($urandom); bus.qc_3 <= 21'($urandom);
        end else begin
            if (bus.in0_rden) begin
                bus.qa_0 <= mem[0][0][bus.rd_addr[4:0]];
                bus.qb_0 <= mem[1][0][bus.rd_addr[4:0]];
                bus.qc_0 <= mem[2][0][bus.rd_addr[4:0]];
            end
            if (bus.in1_rden) begin
                bus.qa_1 <= mem[0][1][bus.rd_addr[4:0]];
                bus.qb_1 <= mem[1][1][bus.rd_addr[4:0]];
                bus.qc_1 <= mem[2][1][bus.rd_addr[4:0]];
            end
            if (bus.in2_rden) begin
                bus.qa_2 <= mem[0][2][bus.rd_addr[4:0]];
                bus.qb_2 <= mem[1][2][bus.rd_addr[4:0]];
                bus.qc_2 <= mem[2][2][bus.rd_addr[4:0]];
            end
            if (bus.in3_rden) begin
                bus.qa_3 <= mem[0][3][bus.rd_addr[4:0]];
                bus.qb_3 <= mem[1][3][bus.rd_addr[4:0]];
                bus.qc_3 <= mem[2][3][bus.rd_addr[4:0]];
            end
        end
    end

    // Output monitor
    int                 de_cyc [$];
    logic signed [20:0] got_a [$], got_b [$], got_c [$];
    int                 fd_at [$];
    int                 ld_cnt, ld_last, fd_cnt, addr_bad, s_exp;
    int                 rd_cnt [4];

    always @(negedge clk) begin
        if (bus.de_out) begin
            de_cyc.push_back(cyc);
            got_a.push_back(bus.pa);
            got_b.push_back(bus.pb);
            got_c.push_back(bus.pc);
        end
        if (bus.line_done) begin
            ld_cnt++;
            ld_last = cyc;
        end
        if (bus.frame_done) begin
            fd_cnt++;
            fd_at.push_back(ld_cnt);
        end
        if (bus.in0_rden) rd_cnt[0]++;
        if (bus.in1_rden) rd_cnt[1]++;
        if (bus.in2_rden) rd_cnt[2]++;
        if (bus.in3_rden) rd_cnt[3]++;
        if (bus.in0_rden || bus.in1_rden || bus.in2_rden || bus.in3_rden) begin
            if ((cyc - s_exp) < 0 || (cyc - s_exp) > W - 1 ||
                bus.rd_addr != 11'(cyc - s_exp)) addr_bad++;
        end
    end

    task automatic clear_mon();
        de_cyc.delete(); got_a.delete(); got_b.delete(); got_c.delete(); fd_at.delete();
        ld_cnt = 0; ld_last = 0; fd_cnt = 0; addr_bad = 0;
        for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic signed [20:0] ea [W/2], eb [W/2], ec [W/2];

    task automatic load_pair01();
        for (int c = 0; c < W; c++) begin
            mem[0][0][c] = 21'(c);      mem[0][1][c] = 21'(c - 5);
            mem[1][0][c] = 21'(-c);     mem[1][1][c] = 21'(-c - 7);
            mem[2][0][c] = 21'sd100;    mem[2][1][c] = 21'sd50;
            for (int ch = 0; ch < 3; ch++) begin
                mem[ch][2][c] = 21'sd500;
                mem[ch][3][c] = 21'sd500;
            end
        end
        for (int k = 0; k < W/2; k++) begin
            ea[k] = 21'(2*k + 1);
            eb[k] = 21'(-2*k);
            ec[k] = 21'sd100;
        end
    endtask

    task automatic load_pair23();
        for (int c = 0; c < W; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                mem[ch][0][c] = 21'sd500;
                mem[ch][1][c] = 21'sd500;
            end
            mem[0][2][c] = -21'sd5;      mem[0][3][c] = -21'sd3;
            mem[1][2][c] = 21'h0FFFFF;   mem[1][3][c] = 21'h100000;
            mem[2][2][c] = (c % 2 == 0) ? 21'h0FFFFF : 21'h100000;
            mem[2][3][c] = 21'h100000;
        end
        for (int k = 0; k < W/2; k++) begin
            ea[k] = -21'sd3;
            eb[k] = 21'h0FFFFF;
            ec[k] = 21'h0FFFFF;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); RESET_n = 1'b0;
        repeat (2) @(negedge clk);
        RESET_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge well after the line has drained.
    task automatic run_line(input logic tog, output int f);
        clear_mon();
        bus.bram_toggle = tog; bus.fin_rd = 1'b1; f = cyc; s_exp = f + 2;
        @(negedge clk); bus.fin_rd = 1'b0;
        repeat (3) @(negedge clk);
        bus.bram_toggle = ~tog;
        repeat (W + 4) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input int f, input logic pair);
        chk($sformatf("%s_nde", tag), de_cyc.size(), W/2);
        for (int k = 0; k < W/2; k++) begin
            if (k < de_cyc.size()) begin
                chk($sformatf("%s_decyc%0d", tag, k), de_cyc[k], f + 5 + 2*k);
                chk($sformatf("%s_pa%0d", tag, k), got_a[k], ea[k]);
                chk($sformatf("%s_pb%0d", tag, k), got_b[k], eb[k]);
                chk($sformatf("%s_pc%0d", tag, k), got_c[k], ec[k]);
            end
        end
        chk($sformatf("%s_ldcnt", tag), ld_cnt, 1);
        chk($sformatf("%s_ldcyc", tag), ld_last, f + W + 3);
        chk($sformatf("%s_fdcnt", tag), fd_cnt, 0);
        chk($sformatf("%s_rden01", tag), {rd_cnt[0], rd_cnt[1]}, pair ? {W, W} : {0, 0});
        chk($sformatf("%s_rden23", tag), {rd_cnt[2], rd_cnt[3]}, pair ? {0, 0} : {W, W});
        chk($sformatf("%s_addrseq", tag), addr_bad, 0);
        chk($sformatf("%s_addr_idle", tag), bus.rd_addr, 0);
    endtask

    int f;

    initial begin
        n_vec = 0; n_err = 0; s_exp = 0;
        RESET_n = 1'b0; bus.fin_rd = 1'b0; bus.bram_toggle = 1'b0;
        clear_mon();
        load_pair01();
        repeat (4) @(negedge clk);

        // Reset state with random bank data
        chk("rst_de",    bus.de_out, 0);
        chk("rst_addr",  bus.rd_addr, 0);
        chk("rst_rden",  {bus.in0_rden, bus.in1_rden, bus.in2_rden, bus.in3_rden}, 0);
        chk("rst_pix",   {bus.pa, bus.pb, bus.pc}, 0);
        chk("rst_flags", {bus.line_done, bus.frame_done, bus.overrun}, 0);
        RESET_n = 1'b1;
        clear_mon();
        repeat (40) @(negedge clk);
        chk("idle_nde",  de_cyc.size(), 0);
        chk("idle_rden", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 0);

        // Bank pair 0/1
        run_line(1'b1, f);
        check_line("p01", f, 1'b1);

        // Bank pair 2/3, signed compares around the sign boundary
        load_pair23();
        run_line(1'b0, f);
        check_line("p23", f, 1'b0);

        // Two frames of back-to-back lines at minimum spacing
        load_pair01();
        do_reset();
        clear_mon();
        for (int i = 0; i < 28; i++) begin
            bus.bram_toggle = 1'b1; bus.fin_rd = 1'b1; s_exp = cyc + 2;
            @(negedge clk); bus.fin_rd = 1'b0;
            repeat (W + 3) @(negedge clk);
        end
        chk("frm_ldcnt", ld_cnt, 28);
        chk("frm_nde",   de_cyc.size(), 28 * (W/2));
        chk("frm_fdcnt", fd_cnt, 2);
        if (fd_at.size() >= 2) begin
            chk("frm_fd_first",  fd_at[0], 14);
            chk("frm_fd_second", fd_at[1], 28);
        end
        chk("frm_overrun", bus.overrun, 0);
        chk("frm_addrseq", addr_bad, 0);

        // Overrun: second request 10 cycles after the first
        do_reset();
        clear_mon();
        bus.bram_toggle = 1'b1; bus.fin_rd = 1'b1; f = cyc; s_exp = f + 2;
        @(negedge clk); bus.fin_rd = 1'b0;
        repeat (8) @(negedge clk);
        chk("ovr_before", bus.overrun, 0);
        @(negedge clk); bus.fin_rd = 1'b1;
        @(negedge clk); bus.fin_rd = 1'b0;
        chk("ovr_set", bus.overrun, 1);
        repeat (39) @(negedge clk);
        check_line("ovr", f, 1'b1);
        chk("ovr_sticky", bus.overrun, 1);
        do_reset();
        chk("ovr_cleared", bus.overrun, 0);

        // Asynchronous reset in the middle of a line
        clear_mon();
        bus.bram_toggle = 1'b1; bus.fin_rd = 1'b1; f = cyc; s_exp = f + 2;
        @(negedge clk); bus.fin_rd = 1'b0;
        repeat (11) @(negedge clk);
        RESET_n = 1'b0;
        #1;
        chk("mrst_de",   bus.de_out, 0);
        chk("mrst_addr", bus.rd_addr, 0);
        chk("mrst_rden", {bus.in0_rden, bus.in1_rden, bus.in2_rden, bus.in3_rden}, 0);
        chk("mrst_pix",  {bus.pa, bus.pb, bus.pc}, 0);
        repeat (2) @(negedge clk);
        RESET_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_nold", ld_cnt, 0);
        run_line(1'b1, f);
        check_line("post", f, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
